// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with in-order imem requests and a credit-limited fetch queue
//
// Purpose: owns the fetch PC and issues sequential word requests to instruction
// memory. Returned words are paired with their request PC and buffered in a small
// fetch queue. The queue head is presented to IF/ID once per cycle. Redirects from
// EX flush the queue and discard every response still in flight. A NOP is presented
// whenever the queue is empty.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   stall              hazard stall: queue head is held, not consumed
//   redirect           PC redirect from EX (highest priority)
//   redirect_pc        redirect target; bits [1:0] forced to zero
//   imem_req/addr      request valid and word address (= fetch PC)
//   imem_gnt           request accepted when imem_req && imem_gnt
//   imem_rvalid/rdata  in-order response, latency >= 1
//   instruction_IF     queue head instruction, or NOP 32'h0000_0033 when empty
//   pc_in_ID           PC of instruction_IF, or 0 when empty
//   if_valid           fetch queue non-empty
//   bubble_cnt         empty non-stalled cycle count (only with IF_PERF_CNT_EN)
//
// Optional feature macro: IF_PERF_CNT_EN
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH        = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [31:0] pc_in_ID,
  output logic        if_valid
`ifdef IF_PERF_CNT_EN
  ,output logic [31:0] bubble_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0033;
  localparam int unsigned CW  = $clog2(FQ_DEPTH + 1);
  localparam int unsigned QPW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]    r_fetch_pc;
  logic [31:0]    r_q_pc   [FQ_DEPTH];
  logic [31:0]    r_q_data [FQ_DEPTH];
  logic [QPW-1:0] r_q_wr;
  logic [QPW-1:0] r_q_rd;
  logic [CW-1:0]  r_q_cnt;
  logic [31:0]    r_tag_pc [MAX_OUTSTANDING];
  logic [TPW-1:0] r_tag_wr;
  logic [TPW-1:0] r_tag_rd;
  logic [CW-1:0]  r_out_cnt;
  logic [CW-1:0]  r_drop_cnt;

  logic           w_valid;
  logic           w_rsp;
  logic           w_push;
  logic           w_pop;
  logic           w_accept;
  logic [CW:0]    w_credit_used;
  logic           w_unused_pc_lsb;

  function automatic logic [QPW-1:0] q_next(input logic [QPW-1:0] p);
    return (p == QPW'(FQ_DEPTH - 1)) ? '0 : p + QPW'(1);
  endfunction

  function automatic logic [TPW-1:0] t_next(input logic [TPW-1:0] p);
    return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
  endfunction

  assign w_unused_pc_lsb = &{1'b0, redirect_pc[1:0]};

  assign w_valid  = !rst && (r_q_cnt != '0);
  // A response with nothing outstanding is stale (e.g. issued before a reset).
  assign w_rsp    = imem_rvalid && (r_out_cnt != '0);
  assign w_push   = w_rsp && !redirect && (r_drop_cnt == '0);
  assign w_pop    = w_valid && !stall && !redirect;

  // Credit = queued + outstanding. A head consumed this cycle frees its slot
  // immediately, which is what sustains one instruction per cycle at depth 2.
  assign w_credit_used = {1'b0, r_out_cnt} + {1'b0, r_q_cnt} - {{CW{1'b0}}, w_pop};
  assign imem_req  = !rst && !redirect
                   && (r_out_cnt < CW'(MAX_OUTSTANDING))
                   && (w_credit_used < (CW+1)'(FQ_DEPTH));
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_gnt;

  assign if_valid       = w_valid;
  assign instruction_IF = w_valid ? r_q_data[r_q_rd] : NOP;
  assign pc_in_ID       = w_valid ? r_q_pc[r_q_rd]   : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_q_wr     <= '0;
      r_q_rd     <= '0;
      r_q_cnt    <= '0;
      r_tag_wr   <= '0;
      r_tag_rd   <= '0;
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (redirect) begin
        r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      // Tags keep flowing through redirects so dropped responses still pop theirs.
      if (w_accept) r_tag_wr <= t_next(r_tag_wr);
      if (w_rsp)    r_tag_rd <= t_next(r_tag_rd);
      r_out_cnt <= r_out_cnt + CW'(w_accept) - CW'(w_rsp);
      if (redirect) begin
        // Everything still in flight after this cycle is wrong-path; the earlier
        // drop backlog is already part of the outstanding count.
        r_drop_cnt <= r_out_cnt - CW'(w_rsp);
        r_q_cnt    <= '0;
        r_q_wr     <= '0;
        r_q_rd     <= '0;
      end else begin
        if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (w_push) r_q_wr <= q_next(r_q_wr);
        if (w_pop)  r_q_rd <= q_next(r_q_rd);
        r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tag_pc[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_q_wr]   <= r_tag_pc[r_tag_rd];
      r_q_data[r_q_wr] <= imem_rdata;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (!stall && !w_valid && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
